// File: rtl/cpu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_seq_pkg
//  Description : Shared types and constants for the cpu instruction sequencer.
//                Holds the sequencer state type and the instruction word width.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_seq_pkg;

    localparam int WORD_W      = 16;
    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_DONE      = 3'd5,
        S_ERR       = 3'd6
    } seq_state_t;

endpackage : cpu_seq_pkg
`default_nettype wire

// File: rtl/cpu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_seq_if
//  Description : Handshake bundle between the sequencer and the cpu.
//                master : sequencer side (drives cpu_in/cpu_load/cpu_s,
//                         observes cpu_w/cpu_out/cpu_N/cpu_V/cpu_Z)
//                slave  : cpu side (the opposite directions)
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_seq_if;
    import cpu_seq_pkg::*;

    logic [WORD_W-1:0] cpu_in;
    logic              cpu_load;
    logic              cpu_s;
    logic              cpu_w;
    logic [WORD_W-1:0] cpu_out;
    logic              cpu_N;
    logic              cpu_V;
    logic              cpu_Z;

    modport master (
        output cpu_in, cpu_load, cpu_s,
        input  cpu_w, cpu_out, cpu_N, cpu_V, cpu_Z
    );

    modport slave (
        input  cpu_in, cpu_load, cpu_s,
        output cpu_w, cpu_out, cpu_N, cpu_V, cpu_Z
    );

endinterface : cpu_seq_if
`default_nettype wire

// File: rtl/cpu_sequencer_prog_mem.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mem
//  Description : DEPTH x WORD_W program store. One synchronous write port,
//                one asynchronous read port, contents not reset.
//  Ports       : clk, i_we/i_waddr/i_wdata (write), i_raddr/o_rdata (read)
//  Revision    : 1.0  initial release
// ============================================================================
module prog_mem
    import cpu_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [AW-1:0]     i_waddr,
    input  wire logic [WORD_W-1:0] i_wdata,
    input  wire logic [AW-1:0]     i_raddr,
    output      logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : prog_mem
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Issues a stored program to the cpu one instruction at a time
//                over the load/s/w handshake and captures each result.
//  Ports       : clk, reset (async, active-high)
//                prog_we/prog_addr/prog_data : program write (idle only)
//                prog_len/go                 : run length and start request
//                cpu                         : cpu handshake (master side)
//                busy/done/err               : run status
//                instr_count, last_out, last_N/V/Z : results of the run
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  wire logic                      clk,
    input  wire logic                      reset,
    input  wire logic                      prog_we,
    input  wire logic [$clog2(DEPTH)-1:0]  prog_addr,
    input  wire logic [WORD_W-1:0]         prog_data,
    input  wire logic [$clog2(DEPTH):0]    prog_len,
    input  wire logic                      go,
    cpu_seq_if.master                      cpu,
    output      logic                      busy,
    output      logic                      done,
    output      logic                      err,
    output      logic [WORD_W-1:0]         instr_count,
    output      logic [WORD_W-1:0]         last_out,
    output      logic                      last_N,
    output      logic                      last_V,
    output      logic                      last_Z
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_t        r_state;
    logic [AW-1:0]     r_pc;
    logic [AW:0]       r_len;
    logic [TW-1:0]     r_tmo;
    logic [WORD_W-1:0] r_cpu_in;
    logic [WORD_W-1:0] r_instr_count;
    logic [WORD_W-1:0] r_last_out;
    logic              r_last_n;
    logic              r_last_v;
    logic              r_last_z;

    logic              w_idle;
    logic              w_we;
    logic [AW-1:0]     w_pc_inc;
    logic [AW-1:0]     w_raddr;
    logic [WORD_W-1:0] w_rdata;
    logic [WORD_W-1:0] w_first;
    logic              w_last;
    logic              w_tmo;

    assign w_idle   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
    assign w_we     = w_idle && prog_we;
    assign w_pc_inc = r_pc + AW'(1);
    // While idle the only word ever needed next is word 0; during a run it
    // is the word after the instruction currently executing.
    assign w_raddr  = w_idle ? '0 : w_pc_inc;
    // A write coinciding with go has not reached the array yet, so forward
    // it when it targets the first word.
    assign w_first  = (w_we && (prog_addr == '0)) ? prog_data : w_rdata;
    assign w_last   = ({1'b0, r_pc} == (r_len - (AW+1)'(1)));
    assign w_tmo    = (r_tmo == TW'(TIMEOUT - 1));

    prog_mem #(
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) u_prog_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_len         <= '0;
            r_tmo         <= '0;
            r_cpu_in      <= '0;
            r_instr_count <= '0;
            r_last_out    <= '0;
            r_last_n      <= 1'b0;
            r_last_v      <= 1'b0;
            r_last_z      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (go) begin
                        r_pc          <= '0;
                        r_len         <= prog_len;
                        r_instr_count <= '0;
                        r_tmo         <= '0;
                        if (prog_len == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cpu_in <= w_first;
                            r_state  <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    r_state <= S_START;
                end
                S_START: begin
                    r_tmo   <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!cpu.cpu_w) begin
                        r_tmo   <= '0;
                        r_state <= S_WAIT_DONE;
                    end else if (w_tmo) begin
                        r_state <= S_ERR;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (cpu.cpu_w) begin
                        r_last_out    <= cpu.cpu_out;
                        r_last_n      <= cpu.cpu_N;
                        r_last_v      <= cpu.cpu_V;
                        r_last_z      <= cpu.cpu_Z;
                        r_instr_count <= r_instr_count + WORD_W'(1);
                        r_pc          <= w_pc_inc;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cpu_in <= w_rdata;
                            r_state  <= S_LOAD;
                        end
                    end else if (w_tmo) begin
                        r_state <= S_ERR;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu.cpu_in   = r_cpu_in;
    assign cpu.cpu_load = (r_state == S_LOAD);
    assign cpu.cpu_s    = (r_state == S_START);

    assign busy        = (r_state == S_LOAD) || (r_state == S_START) ||
                         (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
    assign done        = (r_state == S_DONE);
    assign err         = (r_state == S_ERR);
    assign instr_count = r_instr_count;
    assign last_out    = r_last_out;
    assign last_N      = r_last_n;
    assign last_V      = r_last_v;
    assign last_Z      = r_last_z;

endmodule : cpu_sequencer
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sequencer
//  Description : Self-checking bench for cpu_sequencer. A behavioural cpu stub
//                answers each instruction after random delays with a result
//                defined by alu(); the expected outcome of a run is derived
//                from the shadow copy of the program.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;
    import cpu_seq_pkg::*;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 16;
    localparam int AW      = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              reset;
    logic              prog_we;
    logic [AW-1:0]     prog_addr;
    logic [15:0]       prog_data;
    logic [AW:0]       prog_len;
    logic              go;
    logic              busy, done, err;
    logic [15:0]       instr_count, last_out;
    logic              last_N, last_V, last_Z;

    cpu_seq_if cif ();

    cpu_sequencer #(
        .DEPTH       (DEPTH),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .go          (go),
        .cpu         (cif),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .instr_count (instr_count),
        .last_out    (last_out),
        .last_N      (last_N),
        .last_V      (last_V),
        .last_Z      (last_Z)
    );

    always #5 clk = ~clk;

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          load_cnt  = 0;
    int          pulse_bad = 0;
    int          stub_mode = 0;   // 0 normal, 1 never drops w, 2 never raises w
    logic [15:0] prog [DEPTH];
    logic [15:0] seen [$];

    // Result the stub cpu produces for an instruction word.
    function automatic logic [15:0] alu(input logic [15:0] x);
        return x * 16'd3 + 16'd1;
    endfunction

    // ---------------- cpu stub ----------------
    initial begin : stub
        logic [15:0] instr;
        logic [15:0] r;
        instr        = '0;
        cif.cpu_w    = 1'b1;
        cif.cpu_out  = '0;
        cif.cpu_N    = 1'b0;
        cif.cpu_V    = 1'b0;
        cif.cpu_Z    = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stub_mode == 0) cif.cpu_w = 1'b1;
            if (cif.cpu_load) instr = cif.cpu_in;
            if (cif.cpu_s && stub_mode != 1) begin
                @(posedge clk);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                cif.cpu_w   = 1'b0;
                cif.cpu_out = 16'($urandom);
                cif.cpu_N   = 1'($urandom);
                cif.cpu_V   = 1'($urandom);
                cif.cpu_Z   = 1'($urandom);
                if (stub_mode == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                    r           = alu(instr);
                    cif.cpu_out = r;
                    cif.cpu_N   = r[15];
                    cif.cpu_V   = ^instr;
                    cif.cpu_Z   = (r == 16'h0000);
                    cif.cpu_w   = 1'b1;
                end
            end
        end
    end

    // ---------------- handshake monitor ----------------
    initial begin : mon
        logic pl;
        pl = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (cif.cpu_load) begin
                seen.push_back(cif.cpu_in);
                load_cnt++;
            end
            // load must be a single cycle followed immediately by a single s
            if (pl && !(cif.cpu_s && !cif.cpu_load)) pulse_bad++;
            if (cif.cpu_s && !pl) pulse_bad++;
            pl = cif.cpu_load;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic write_word(input int addr, input logic [15:0] data);
        prog_we   = 1'b1;
        prog_addr = addr[AW-1:0];
        prog_data = data;
        tick();
        prog_we   = 1'b0;
        prog[addr] = data;
    endtask

    task automatic start(input int len);
        seen.delete();
        prog_len = len[AW:0];
        go       = 1'b1;
        tick();
        go       = 1'b0;
    endtask

    task automatic wait_end(input int bound, output int cyc);
        cyc = 0;
        while (!(done || err) && cyc < bound) begin
            tick();
            cyc++;
        end
    endtask

    task automatic check_run(input string tag, input int len);
        int cyc;
        logic [15:0] r;
        wait_end(len * 12 + 40, cyc);
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " err"}, err, 1'b0);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " count"}, instr_count, len);
        r = alu(prog[len-1]);
        chk({tag, " last_out"}, last_out, r);
        chk({tag, " flags"}, {last_N, last_V, last_Z}, {r[15], ^prog[len-1], r == 16'h0000});
        chk({tag, " issued"}, seen.size(), len);
        for (int i = 0; i < len && i < seen.size(); i++) begin
            chk({tag, " instr"}, seen[i], prog[i]);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int cyc;
        int len;
        int lc;
        logic [15:0] nw;

        reset     = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        prog_len  = '0;
        go        = 1'b0;
        repeat (3) tick();
        chk("rst status", {busy, done, err}, 3'b000);
        chk("rst handshake", {cif.cpu_load, cif.cpu_s}, 2'b00);
        chk("rst cpu_in", cif.cpu_in, 16'h0000);
        chk("rst count", instr_count, 16'h0000);
        chk("rst last", {last_out, last_N, last_V, last_Z}, 19'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) write_word(i, 16'($urandom));
        write_word(0, 16'hD007);
        write_word(1, 16'hD102);
        write_word(2, 16'hA148);

        // three-instruction program with pulse timing
        start(3);
        chk("p3 load", {cif.cpu_load, cif.cpu_s, busy, done}, 4'b1010);
        chk("p3 cpu_in", cif.cpu_in, 16'hD007);
        tick();
        chk("p3 start", {cif.cpu_load, cif.cpu_s}, 2'b01);
        tick();
        chk("p3 s end", {cif.cpu_load, cif.cpu_s}, 2'b00);
        check_run("p3", 3);

        // restart from DONE clears status and count
        start(5);
        chk("restart clr", {done, busy, instr_count}, {1'b0, 1'b1, 16'h0000});
        check_run("restart", 5);

        // randomized programs and the full-depth boundary
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < 3; k++) write_word($urandom_range(0, DEPTH-1), 16'($urandom));
            len = (t == 0) ? DEPTH : $urandom_range(1, DEPTH);
            start(len);
            check_run("rand", len);
        end

        // zero-length run
        lc = load_cnt;
        start(0);
        chk("zero done", {done, busy, err}, 3'b100);
        chk("zero count", instr_count, 16'h0000);
        repeat (4) tick();
        chk("zero no load", load_cnt, lc);

        // write coinciding with go reaches the run
        nw        = 16'($urandom);
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_data = nw;
        prog[0]   = nw;
        start(2);
        prog_we   = 1'b0;
        check_run("we+go", 2);

        // go and prog_we during WAIT_DONE are ignored
        start(4);
        cyc = 0;
        while (cif.cpu_w !== 1'b0 && cyc < 40) begin tick(); cyc++; end
        tick();
        chk("ign busy", busy, 1'b1);
        go        = 1'b1;
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_data = 16'hFFFF;
        tick();
        go        = 1'b0;
        prog_we   = 1'b0;
        check_run("ignored", 4);
        start(1);
        check_run("ign readback", 1);

        // reset during WAIT_DONE of the second instruction
        start(4);
        cyc = 0;
        while (instr_count != 16'd1 && cyc < 60) begin tick(); cyc++; end
        while (cif.cpu_w !== 1'b0 && cyc < 60) begin tick(); cyc++; end
        tick();
        chk("mid busy", {busy, instr_count}, {1'b1, 16'd1});
        #1 reset = 1'b1;
        #1;
        chk("mid rst status", {busy, done, err, cif.cpu_load, cif.cpu_s}, 5'b0);
        chk("mid rst data", {cif.cpu_in, instr_count, last_out}, 48'h0);
        chk("mid rst flags", {last_N, last_V, last_Z}, 3'b000);
        tick();
        reset = 1'b0;
        repeat (6) tick();
        start(4);
        check_run("after rst", 4);

        // cpu never drops w: timeout in WAIT_BUSY
        stub_mode = 1;
        start(1);
        cyc = 0;
        while (!err && cyc < 4 * TIMEOUT) begin tick(); cyc++; end
        chk("stuck cycles", cyc, TIMEOUT + 2);
        chk("stuck status", {err, done, busy}, 3'b100);
        chk("stuck count", instr_count, 16'h0000);

        // cpu never raises w: timeout in WAIT_DONE
        stub_mode = 2;
        start(1);
        wait_end(4 * TIMEOUT, cyc);
        chk("hang status", {err, done, busy}, 3'b100);
        chk("hang count", instr_count, 16'h0000);
        stub_mode = 0;
        repeat (3) tick();

        // recovery from ERR
        start(3);
        check_run("recover", 3);

        chk("pulse shape", pulse_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_cpu_sequencer
`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction-issuing front end for the `cpu` block. It holds a small writable program memory and drives the cpu's `in`/`load`/`s` handshake one instruction at a time, honouring the cpu's `w` (waiting) indication. After each instruction it captures the cpu's `out` and N/V/Z results. It replaces hand-driven stimulus and lets a program run unattended on the cpu.

## Interface

**Parameters**
- `DEPTH`, default 16: program memory words; a power of two, at least 2.
- `TIMEOUT`, default 64: maximum cycles allowed in each wait phase before an error is flagged.

**Ports**
- `clk` in, 1: the single clock; all state changes on its rising edge.
- `reset` in, 1: asynchronous, active-high.
- `prog_we` in, 1: program write strobe. Honoured only in IDLE, DONE and ERR.
- `prog_addr` in, AW: program write address, where AW = $clog2(DEPTH).
- `prog_data` in, 16: instruction word to write.
- `prog_len` in, AW+1: number of instructions to run, 0..DEPTH. Sampled when `go` is accepted.
- `go` in, 1: start request. Honoured only in IDLE, DONE and ERR.
- `cpu_w` in, 1: cpu `w`.
- `cpu_out` in, 16: cpu `out`.
- `cpu_N`, `cpu_V`, `cpu_Z` in, 1 each: cpu status flags.
- `cpu_in` out, 16: drives cpu `in`.
- `cpu_load` out, 1: drives cpu `load`.
- `cpu_s` out, 1: drives cpu `s`.
- `busy` out, 1: a run is in progress.
- `done` out, 1: the last run completed normally.
- `err` out, 1: the last run timed out.
- `instr_count` out, 16: instructions completed in the current or last run.
- `last_out` out, 16: `cpu_out` captured at each completion.
- `last_N`, `last_V`, `last_Z` out, 1 each: flags captured alongside `last_out`.

## Operation

**States:** IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, DONE, ERR.

**Reset**
- State goes to IDLE; pc = 0.
- Every output is 0, including `cpu_in`, `instr_count`, `last_*`, `done` and `err`.
- Program memory contents are not reset.

**Transitions**
- IDLE / DONE / ERR, `go`=1:
  - Clear `done`, `err`, `instr_count` and pc; latch `prog_len`.
  - If `prog_len`=0: go to DONE (no cpu activity).
  - Otherwise: go to LOAD.
- LOAD:
  - `cpu_in` = mem[pc] (registered), `cpu_load` = 1.
  - Go to START.
- START:
  - `cpu_load` = 0, `cpu_s` = 1.
  - Go to WAIT_BUSY.
- WAIT_BUSY: wait for `cpu_w`=0, then go to WAIT_DONE.
- WAIT_DONE: wait for `cpu_w`=1. On that cycle:
  - Capture `last_out` and `last_N/V/Z`.
  - `instr_count`++ (16-bit, wraps at 16'hFFFF); pc++.
  - If pc = len-1: go to DONE. Otherwise go to LOAD.
- Timeout: each wait state has its own cycle counter, cleared on entry. If the condition is still unmet after TIMEOUT cycles, go to ERR.
- DONE: `done` = 1, held until the next accepted `go`.
- ERR: `err` = 1, held until the next accepted `go`.

**Other rules**
- `busy` = 1 in LOAD, START, WAIT_BUSY and WAIT_DONE.
- `go` and `prog_we` while busy are ignored.
- If `go` and `prog_we` coincide, the write lands first; the run reads the new word.
- Reset mid-run aborts immediately. All outputs return to 0, including `cpu_load` and `cpu_s`, which are never left high.

## Timing

- Outputs are registered or decoded from the state register. There are no combinational paths from inputs to outputs.
- A `go` sampled at edge k puts the block in LOAD from edge k+1: `cpu_load` is high for exactly that one cycle.
- `cpu_s` is high for exactly the next cycle.
- `cpu_in` is stable from its LOAD cycle until the next LOAD.
- A `cpu_w`=1 sampled at edge j of WAIT_DONE gives `last_*` and `instr_count` their new values after edge j, and the next LOAD starts at edge j+1.
- Minimum per instruction: 4 cycles (LOAD, START, 1×WAIT_BUSY, 1×WAIT_DONE).
- With `prog_len`=0, `done` rises one cycle after `go`.

## Structure

- Package `cpu_seq_pkg` holds:
  - the state enum `seq_state_t`;
  - `WORD_W` = 16;
  - the state encodings.
- Sub-module `prog_mem`:
  - DEPTH×16 flop array;
  - one synchronous write port;
  - one asynchronous read port;
  - no reset.

## Test plan

- **Three-instruction program.** Write 16'hD007, 16'hD102, 16'hA148 (MOV R0,#7; MOV R1,#2; ADD R2,R1,R0,LSL#1) to the real `cpu`; `prog_len`=3, `go` → `done`=1, `instr_count`=3, `last_out`=16'h0010, N=V=Z=0, cpu R2=16'h0010. Check each `cpu_load` and `cpu_s` is a one-cycle pulse in consecutive cycles.
- **Zero-length run.** `prog_len`=0, `go` → `done`=1 one cycle later; `cpu_load` never asserted; `instr_count`=0.
- **Stuck cpu.** Stub cpu holds `cpu_w`=1 permanently; `prog_len`=1 → `err`=1 after TIMEOUT cycles in WAIT_BUSY; `busy`=0; `done`=0.
- **Ignored requests.** `go` pulse and `prog_we` to address 0 with 16'hFFFF during WAIT_DONE of a run → run unaffected; mem[0] unchanged on readback by a rerun.
- **Reset mid-run.** Assert `reset` during WAIT_DONE of instruction 2 → all outputs 0 immediately. A following `go` reruns from pc=0 with memory intact.
- **Restart from DONE.** `go` while in DONE clears `done` and `instr_count`, then the program reruns.
